sdr_init_checker: RTL and testbench
===================================

# sdr_init_checker

Synthesizable, parametrised checker of the SDRAM power-up command sequence, sampling the controller's SDRAM command bus. It tracks the reset → NOP hold → precharge-all → N × auto-refresh → mode-register-set sequence with a per-step timeout. Violations are reported as sticky, encoded flags plus a saturating counter, so the same check runs in simulation, emulation and silicon debug. It is a passive tap on the controller-to-SDRAM pins; it never drives the bus.

## Interface
Parameters:
- NOP_CYCLES, 500: minimum consecutive NOP cycles after reset release before the first command.
- STEP_TIMEOUT, 100: maximum NOP cycles allowed between consecutive required commands.
- AREF_COUNT, 2: auto-refresh commands required before MRS (≥1).
- CS_W, 1: chip-select width, one bit per rank.
- SDR_AW, 13: SDRAM address width (≥11).

Ports:
- sdram_clk  in  1  clock; all inputs sampled on rising edge.
- sdram_resetn  in  1  reset, asynchronous, active-low.
- sdr_cs_n  in  CS_W  chip selects.
- sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  command pins.
- sdr_addr  in  SDR_AW  address bus.
- chk_clr  in  1  clears error state and re-arms the checker at WAIT_NOP.
- init_done  out  1  sequence completed legally.
- err  out  1  sticky violation flag.
- err_code  out  3  first violation: 0 none, 1 EARLY, 2 ORDER, 3 TIMEOUT, 4 PREALL, 5 CS.
- err_cnt  out  8  violation events, saturating at 255.
- mode_q  out  SDR_AW  address captured on MRS.
- state_o  out  3  0 WAIT_NOP, 1 PRE_WAIT, 2 AREF_WAIT, 3 MRS_WAIT, 4 DONE, 5 FAIL.

## Operation
- Command decode uses {ras_n, cas_n, we_n}:
  - NOP = HHH, or sdr_cs_n all ones.
  - PRE = LHL, AREF = LLH, MRS = LLL.
  - Any other code is "other".
  - A command is valid only when sdr_cs_n is all zeros.
  - Any partial cs_n pattern other than all ones or all zeros before DONE → CS violation.
- WAIT_NOP:
  - Counts consecutive NOPs.
  - Any non-NOP before the count reaches NOP_CYCLES → EARLY.
  - At count == NOP_CYCLES → PRE_WAIT, timeout counter cleared.
- PRE_WAIT:
  - PRE with sdr_addr[10]=1 → AREF_WAIT.
  - PRE with addr[10]=0 → PREALL.
  - AREF, MRS or other → ORDER.
  - More than STEP_TIMEOUT NOPs → TIMEOUT.
- AREF_WAIT:
  - Each AREF increments the refresh count and clears the timeout counter.
  - On the AREF_COUNT-th AREF → MRS_WAIT.
  - PRE is tolerated (timeout cleared).
  - MRS or other → ORDER.
  - Timeout rule as above.
- MRS_WAIT:
  - MRS → mode_q ← sdr_addr, DONE.
  - AREF or PRE tolerated.
  - Other → ORDER.
  - Timeout rule as above.
- DONE: init_done=1; no further checking.
- FAIL:
  - Entered on any violation; err=1, err_code holds the first cause, err_cnt increments by 1 (saturating).
  - Stays in FAIL until chk_clr or reset.
- Width rules:
  - Step/NOP counter width = $clog2(max(NOP_CYCLES, STEP_TIMEOUT)+1).
  - Refresh counter width = $clog2(AREF_COUNT+1).
  - Counters stop at their terminal value and never wrap.

## Timing
- Reset values: init_done=0, err=0, err_code=0, err_cnt=0, mode_q=0, state_o=0 (WAIT_NOP), all counters 0.
- Latency: a violation sampled at edge N shows on err/err_code/err_cnt after edge N. A legal MRS at edge N sets init_done and mode_q after edge N.
- Timeout boundary: the TIMEOUT flag sets on the edge that samples the (STEP_TIMEOUT+1)-th consecutive NOP in a waiting state.
- Exact-boundary command: a required command on the edge of the STEP_TIMEOUT-th NOP-free slot is legal.
- Simultaneous chk_clr and violation: chk_clr wins. The next state is WAIT_NOP, err/err_code clear, and err_cnt is not incremented; err_cnt is preserved by chk_clr.
- Simultaneous CS and decode violations in one cycle: err_code = 5 (CS has priority).
- Reset mid-sequence: asynchronous return of every output and counter to its reset value, including err_cnt.
- chk_clr in DONE: returns to WAIT_NOP, init_done → 0, mode_q retained.

## Test plan
- Legal sequence: reset release, 500 NOP, PRE addr=0x400, 20 NOP, AREF, 30 NOP, AREF, MRS addr=0x033 → init_done=1 one cycle after MRS, mode_q=0x033, err=0, state_o=4.
- Early command: PRE after 499 NOPs → err=1, err_code=1, err_cnt=1, state_o=5.
- Timeout: 500 NOP, PRE-all, 101 NOP → err_code=3 on the 101st NOP. Repeat with 100 NOP then AREF → no error.
- Order/PREALL: MRS after only 1 AREF → err_code=2. A separate run with PRE addr=0x000 → err_code=4.
- Partial chip select (CS_W=2): cs_n=2'b01 during AREF_WAIT → err_code=5. The same cycle with chk_clr=1 → no error, state_o=0, err_cnt unchanged.
- Reset mid-sequence: assert sdram_resetn low during AREF_WAIT with err_cnt=3 → all outputs 0 immediately; the full legal sequence afterwards completes with init_done=1.

Source files
------------

// File: rtl/sdr_init_checker.sv
// sdr_init_checker: passive monitor of the SDRAM power-up command sequence
// (NOP hold -> PRE-all -> N x AREF -> MRS) with per-step timeout and sticky error
// reporting. It only samples the controller-to-SDRAM pins and never drives them.
module sdr_init_checker #(
  parameter int NOP_CYCLES   = 500,
  parameter int STEP_TIMEOUT = 100,
  parameter int AREF_COUNT   = 2,
  parameter int CS_W         = 1,
  parameter int SDR_AW       = 13
) (
  input  logic              sdram_clk,
  input  logic              sdram_resetn,
  input  logic [CS_W-1:0]   sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [SDR_AW-1:0] sdr_addr,
  input  logic              chk_clr,
  output logic              init_done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [7:0]        err_cnt,
  output logic [SDR_AW-1:0] mode_q,
  output logic [2:0]        state_o
);

  localparam int CNT_MAX = (NOP_CYCLES > STEP_TIMEOUT) ? NOP_CYCLES : STEP_TIMEOUT;
  localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int RW      = $clog2(AREF_COUNT + 1);

  localparam logic [CW-1:0] L_NOP_LAST = CW'(NOP_CYCLES - 1);
  localparam logic [CW-1:0] L_TIMEOUT  = CW'(STEP_TIMEOUT);
  localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] L_REF_LAST = RW'(AREF_COUNT - 1);
  localparam logic [RW-1:0] L_REF_ONE  = RW'(1);

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_EARLY   = 3'd1;
  localparam logic [2:0] E_ORDER   = 3'd2;
  localparam logic [2:0] E_TIMEOUT = 3'd3;
  localparam logic [2:0] E_PREALL  = 3'd4;
  localparam logic [2:0] E_CS      = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT_NOP  = 3'd0,
    S_PRE_WAIT  = 3'd1,
    S_AREF_WAIT = 3'd2,
    S_MRS_WAIT  = 3'd3,
    S_DONE      = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_aref;
  logic [2:0]        r_code;
  logic [7:0]        r_err_cnt;
  logic [SDR_AW-1:0] r_mode;

  state_t            w_nxt_state;
  logic [CW-1:0]     w_nxt_cnt;
  logic [RW-1:0]     w_nxt_aref;
  logic [2:0]        w_code;
  logic              w_mrs_hit;

  logic       w_cs_none;
  logic       w_cs_all;
  logic       w_cs_bad;
  logic [2:0] w_cmd;
  logic       w_nop;
  logic       w_pre;
  logic       w_aref;
  logic       w_mrs;
  logic       w_checking;

  // A deselected bus is a NOP whatever the command pins say; a command only
  // counts when every rank is selected, and mixed selects are a fault of their own.
  assign w_cs_none  = &sdr_cs_n;
  assign w_cs_all   = ~|sdr_cs_n;
  assign w_cs_bad   = !w_cs_none && !w_cs_all;
  assign w_cmd      = {sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign w_nop      = w_cs_none || (w_cs_all && w_cmd == 3'b111);
  assign w_pre      = w_cs_all && w_cmd == 3'b010;
  assign w_aref     = w_cs_all && w_cmd == 3'b001;
  assign w_mrs      = w_cs_all && w_cmd == 3'b000;
  assign w_checking = r_state inside {S_WAIT_NOP, S_PRE_WAIT, S_AREF_WAIT, S_MRS_WAIT};

  // Next-state, counter and violation decode; CS beats decode faults, chk_clr beats everything.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_aref  = r_aref;
    w_code      = E_NONE;
    w_mrs_hit   = 1'b0;
    case (r_state)
      S_WAIT_NOP: begin
        if (!w_nop) w_code = E_EARLY;
        else if (r_cnt == L_NOP_LAST) begin
          w_nxt_state = S_PRE_WAIT;
          w_nxt_cnt   = '0;
        end else w_nxt_cnt = r_cnt + L_CNT_ONE;
      end
      S_PRE_WAIT: begin
        if (w_nop) begin
          if (r_cnt == L_TIMEOUT) w_code = E_TIMEOUT;
          else w_nxt_cnt = r_cnt + L_CNT_ONE;
        end else if (!w_pre) w_code = E_ORDER;
        else if (!sdr_addr[10]) w_code = E_PREALL;
        else begin
          w_nxt_state = S_AREF_WAIT;
          w_nxt_cnt   = '0;
          w_nxt_aref  = '0;
        end
      end
      S_AREF_WAIT: begin
        if (w_nop) begin
          if (r_cnt == L_TIMEOUT) w_code = E_TIMEOUT;
          else w_nxt_cnt = r_cnt + L_CNT_ONE;
        end else if (w_aref) begin
          w_nxt_cnt = '0;
          if (r_aref == L_REF_LAST) w_nxt_state = S_MRS_WAIT;
          else w_nxt_aref = r_aref + L_REF_ONE;
        end else if (w_pre) w_nxt_cnt = '0;
        else w_code = E_ORDER;
      end
      S_MRS_WAIT: begin
        if (w_nop) begin
          if (r_cnt == L_TIMEOUT) w_code = E_TIMEOUT;
          else w_nxt_cnt = r_cnt + L_CNT_ONE;
        end else if (w_mrs) begin
          w_nxt_state = S_DONE;
          w_mrs_hit   = 1'b1;
        end else if (w_aref || w_pre) w_nxt_cnt = '0;
        else w_code = E_ORDER;
      end
      default: ;
    endcase
    if (w_checking && w_cs_bad) w_code = E_CS;
    if (w_code != E_NONE) begin
      w_nxt_state = S_FAIL;
      w_nxt_cnt   = '0;
      w_nxt_aref  = '0;
      w_mrs_hit   = 1'b0;
    end
    if (chk_clr) begin
      w_nxt_state = S_WAIT_NOP;
      w_nxt_cnt   = '0;
      w_nxt_aref  = '0;
      w_code      = E_NONE;
      w_mrs_hit   = 1'b0;
    end
  end

  // Sequence state and step/refresh counters.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state <= S_WAIT_NOP;
      r_cnt   <= '0;
      r_aref  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_aref  <= w_nxt_aref;
    end
  end

  // First-cause error code held until chk_clr; event counter survives chk_clr and saturates.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_code    <= E_NONE;
      r_err_cnt <= '0;
    end else begin
      r_code    <= chk_clr ? E_NONE : (w_code != E_NONE ? w_code : r_code);
      r_err_cnt <= (w_code != E_NONE && r_err_cnt != 8'hFF) ? r_err_cnt + 8'd1 : r_err_cnt;
    end
  end

  // Mode register image captured from the legal MRS; kept across chk_clr.
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) r_mode <= '0;
    else if (w_mrs_hit) r_mode <= sdr_addr;
  end

  assign init_done = r_state == S_DONE;
  assign err       = r_state == S_FAIL;
  assign err_code  = r_code;
  assign err_cnt   = r_err_cnt;
  assign mode_q    = r_mode;
  assign state_o   = r_state;

endmodule

// File: tb/tb_sdr_init_checker.sv
// tb_sdr_init_checker: scoreboard bench for sdr_init_checker with directed and random sequences.
module tb_sdr_init_checker;
  localparam int NOP_C  = 500;
  localparam int TO     = 100;
  localparam int AREF_N = 2;
  localparam int CSW    = 2;
  localparam int AW     = 13;

  localparam logic [2:0] C_NOP  = 3'b111;
  localparam logic [2:0] C_PRE  = 3'b010;
  localparam logic [2:0] C_AREF = 3'b001;
  localparam logic [2:0] C_MRS  = 3'b000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [CSW-1:0] cs = 2'b11;
  logic           ras = 1'b1, cas = 1'b1, we = 1'b1;
  logic [AW-1:0]  addr = '0;
  logic           clr = 1'b0;
  logic           init_done, err;
  logic [2:0]     err_code, state_o;
  logic [7:0]     err_cnt;
  logic [AW-1:0]  mode_q;

  always #5 clk = ~clk;

  sdr_init_checker #(
    .NOP_CYCLES(NOP_C), .STEP_TIMEOUT(TO), .AREF_COUNT(AREF_N), .CS_W(CSW), .SDR_AW(AW)
  ) dut (
    .sdram_clk(clk), .sdram_resetn(rst_n), .sdr_cs_n(cs), .sdr_ras_n(ras), .sdr_cas_n(cas),
    .sdr_we_n(we), .sdr_addr(addr), .chk_clr(clr), .init_done(init_done), .err(err),
    .err_code(err_code), .err_cnt(err_cnt), .mode_q(mode_q), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          done;
    logic          er;
    logic [2:0]    code;
    logic [7:0]    cnt;
    logic [AW-1:0] mode;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: phase 0..5, NOPs since the last step event, refreshes seen.
  int m_phase = 0, m_nops = 0, m_refs = 0, m_code = 0, m_cnt = 0;
  logic [AW-1:0] m_mode = '0;

  function automatic void model_reset();
    m_phase = 0; m_nops = 0; m_refs = 0; m_code = 0; m_cnt = 0; m_mode = '0;
  endfunction

  function automatic void model_step(input logic [1:0] c_s, input logic [2:0] c,
                                     input logic [AW-1:0] a, input logic cl);
    int v;
    bit sel, nop, pre, ar, mrs;
    v   = 0;
    sel = (c_s == 2'b00);
    nop = (c_s == 2'b11) || (sel && c == C_NOP);
    pre = sel && c == C_PRE;
    ar  = sel && c == C_AREF;
    mrs = sel && c == C_MRS;
    if (m_phase < 4) begin
      if (!sel && c_s != 2'b11) v = 5;
      else if (m_phase == 0) begin
        if (!nop) v = 1;
        else begin
          m_nops++;
          if (m_nops == NOP_C) begin m_phase = 1; m_nops = 0; end
        end
      end else if (nop) begin
        if (m_nops == TO) v = 3; else m_nops++;
      end else if (m_phase == 1) begin
        if (!pre) v = 2;
        else if (!a[10]) v = 4;
        else begin m_phase = 2; m_nops = 0; m_refs = 0; end
      end else if (m_phase == 2) begin
        if (ar) begin
          m_nops = 0;
          m_refs++;
          if (m_refs == AREF_N) m_phase = 3;
        end else if (pre) m_nops = 0;
        else v = 2;
      end else begin
        if (mrs) begin
          if (!cl) m_mode = a;
          m_phase = 4;
        end else if (ar || pre) m_nops = 0;
        else v = 2;
      end
    end
    if (cl) begin
      m_phase = 0; m_nops = 0; m_refs = 0; m_code = 0;
    end else if (v != 0) begin
      m_phase = 5; m_code = v; m_nops = 0; m_refs = 0;
      if (m_cnt < 255) m_cnt++;
    end
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.st   = 3'(m_phase);
    e.done = (m_phase == 4);
    e.er   = (m_phase == 5);
    e.code = 3'(m_code);
    e.cnt  = 8'(m_cnt);
    e.mode = m_mode;
    return e;
  endfunction

  // Monitor: every entry pushed at a negedge is due just after the following posedge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{state_o, init_done, err, err_code, err_cnt, mode_q};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got st=%0d done=%0b err=%0b code=%0d cnt=%0d mode=%h, expected st=%0d done=%0b err=%0b code=%0d cnt=%0d mode=%h",
                   $time, a.st, a.done, a.er, a.code, a.cnt, a.mode,
                   e.st, e.done, e.er, e.code, e.cnt, e.mode);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_now(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    end
  endtask

  task automatic cyc(input logic [1:0] c_s, input logic [2:0] c, input logic [AW-1:0] a,
                     input logic cl);
    @(negedge clk);
    cs = c_s;
    {ras, cas, we} = c;
    addr = a;
    clr = cl;
    model_step(c_s, c, a, cl);
    q.push_back(model_exp());
  endtask

  task automatic cmd(input logic [2:0] c, input logic [AW-1:0] a);
    cyc(2'b00, c, a, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom % 2 == 0) cyc(2'b11, 3'($urandom), AW'($urandom), 1'b0);
      else cyc(2'b00, C_NOP, AW'($urandom), 1'b0);
    end
  endtask

  task automatic clear();
    cyc(2'b11, C_NOP, '0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cs = 2'b11;
    {ras, cas, we} = C_NOP;
    addr = '0;
    clr = 1'b0;
    model_reset();
    #1;
    expect_now("async_reset", {state_o, init_done, err, err_code, err_cnt, mode_q}, 32'd0);
    q.push_back(model_exp());
    repeat (2) begin
      @(negedge clk);
      q.push_back(model_exp());
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic legal_seq();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    nops(20);
    cmd(C_AREF, '0);
    nops(30);
    cmd(C_AREF, '0);
    cmd(C_MRS, 13'h033);
    nops(1);
  endtask

  initial begin
    int g, r;
    do_reset();
    legal_seq();
    expect_now("legal_init_done", init_done, 1);
    expect_now("legal_mode_q", mode_q, 13'h033);
    expect_now("legal_err", err, 0);
    expect_now("legal_state", state_o, 4);
    clear();
    nops(1);
    expect_now("clr_done_state", state_o, 0);
    expect_now("clr_done_init", init_done, 0);
    expect_now("clr_done_mode", mode_q, 13'h033);

    do_reset();
    nops(NOP_C - 1);
    cmd(C_PRE, 13'h400);
    nops(1);
    expect_now("early_err", err, 1);
    expect_now("early_code", err_code, 1);
    expect_now("early_cnt", err_cnt, 1);
    expect_now("early_state", state_o, 5);

    clear();
    nops(NOP_C);
    cmd(C_PRE, 13'h000);
    nops(1);
    expect_now("preall_code", err_code, 4);
    expect_now("preall_cnt", err_cnt, 2);

    clear();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    cmd(C_AREF, '0);
    cmd(C_MRS, 13'h011);
    nops(1);
    expect_now("order_code", err_code, 2);
    expect_now("order_cnt", err_cnt, 3);

    clear();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    nops(3);
    cyc(2'b01, C_NOP, '0, 1'b1);
    nops(1);
    expect_now("cs_clr_state", state_o, 0);
    expect_now("cs_clr_err", err, 0);
    expect_now("cs_clr_cnt", err_cnt, 3);

    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    cmd(C_AREF, '0);
    nops(1);
    expect_now("mid_state", state_o, 2);
    expect_now("mid_cnt", err_cnt, 3);
    do_reset();
    legal_seq();
    expect_now("relegal_init_done", init_done, 1);

    clear();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    nops(2);
    cyc(2'b10, C_AREF, '0, 1'b0);
    nops(1);
    expect_now("cs_code", err_code, 5);
    expect_now("cs_cnt", err_cnt, 1);

    do_reset();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    nops(TO);
    nops(1);
    expect_now("to_edge_err", err, 0);
    nops(1);
    expect_now("timeout_code", err_code, 3);
    expect_now("timeout_state", state_o, 5);

    do_reset();
    nops(NOP_C);
    cmd(C_PRE, 13'h400);
    nops(TO);
    cmd(C_AREF, '0);
    nops(1);
    expect_now("to_boundary_err", err, 0);
    expect_now("to_boundary_state", state_o, 2);

    do_reset();
    nops(NOP_C + TO);
    cmd(C_PRE, 13'h400);
    nops(1);
    expect_now("pre_boundary_state", state_o, 2);

    for (int t = 0; t < 24; t++) begin
      if ($urandom % 4 == 0) do_reset(); else clear();
      nops(($urandom % 5 == 0) ? $urandom_range(NOP_C - 5, NOP_C - 1) : NOP_C);
      for (int s = 0; s < 4; s++) begin
        g = ($urandom % 5 == 0) ? $urandom_range(TO - 3, TO + 2) : $urandom_range(0, 15);
        nops(g);
        r = $urandom % 100;
        if (r < 12) cyc(2'($urandom), 3'($urandom), AW'($urandom), 1'($urandom % 3 == 0));
        else if (s == 0)
          cmd(C_PRE, ($urandom % 6 == 0) ? (AW'($urandom) & ~13'h400) : (AW'($urandom) | 13'h400));
        else if (s < 3) cmd(C_AREF, AW'($urandom));
        else cmd(C_MRS, AW'($urandom));
      end
      nops($urandom_range(1, 5));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
